// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame-buffer write path (ntsc_write) and its
// display-side reader: pixel/word/address widths, the default frame size,
// the pack and write FSM state encodings, and the address-advance helper.
// -----------------------------------------------------------------------------
package frame_pkg;

   localparam int PIXEL_W     = 18;                 // {r[5:0], g[5:0], b[5:0]}
   localparam int WORD_W      = 2 * PIXEL_W;        // {first_pixel, second_pixel}
   localparam int ADDR_W      = 18;
   localparam int ENTRY_W     = ADDR_W + WORD_W;    // FIFO entry {addr, word}
   localparam int FRAME_WORDS = 153600;             // 640x480 / 2

   typedef enum logic {
      PACK_EMPTY = 1'b0,
      PACK_HALF  = 1'b1
   } pack_state_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_REQ  = 1'b1
   } wr_state_t;

   // Frame address advance: the last word of a frame is followed by 0.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                   input logic [ADDR_W-1:0] last);
      if (addr == last)
         return '0;
      return addr + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/word_fifo.sv
// -----------------------------------------------------------------------------
// word_fifo
// Synchronous show-ahead FIFO holding {addr, word} entries for ntsc_write.
// The head entry is always visible on rd_data; rd_data_next shows the entry
// behind it so the consumer can present it on the cycle after a pop.
// A push while full is accepted only when a pop happens in the same cycle.
//
// Parameters: DEPTH (power of two, >= 2), DATA_W (entry width).
// Ports:
//   clock, reset        - system clock, asynchronous active-high reset
//   push, wr_data       - write request and entry
//   pop                 - remove the head entry
//   rd_data             - head entry
//   rd_data_next        - entry behind the head (valid when more = 1)
//   full, empty, more   - status; more = at least two entries held
// -----------------------------------------------------------------------------
module word_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 54
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] rd_data_next,
   output logic              full,
   output logic              empty,
   output logic              more
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign more    = (count > CNT_W'(1));
   assign do_pop  = pop && !empty;
   // When full, the slot under wr_ptr is the head being popped this cycle.
   assign do_push = push && (!full || do_pop);

   assign rd_data      = mem[rd_ptr];
   assign rd_data_next = mem[rd_ptr + PTR_W'(1)];

   // Storage carries data only and needs no reset.
   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ntsc_write.sv
// -----------------------------------------------------------------------------
// ntsc_write
// Camera-side frame-buffer writer. Packs pairs of 18-bit pixels into 36-bit
// words {first, second}, tags each with a sequential frame address, queues
// them in word_fifo and writes them to the memory arbiter through the
// ntsc_flag / done_ntsc handshake.
//
// Optional feature macro: NTSC_WRITE_STATS_EN adds a saturating 16-bit
// drop_count output counting words lost to a full FIFO.
//
// Parameters: FRAME_WORDS (words per frame), FIFO_DEPTH (power of two, >= 2).
// Ports:
//   clock, reset   - system clock, asynchronous active-high reset
//   frame_flag     - start-of-frame strobe (drops half pixel, address to 0)
//   pixel          - input pixel {r, g, b}, qualified by pixel_valid
//   ntsc_flag      - write request to the arbiter
//   ntsc_pixel     - write data {first_pixel, second_pixel}
//   ntsc_addr      - word address of ntsc_pixel
//   done_ntsc      - arbiter accepted the current word
//   overflow       - pulse: a completed word was dropped (FIFO full)
//   frame_done     - pulse: the last word of a frame was accepted
//   drop_count     - (NTSC_WRITE_STATS_EN only) dropped-word count
// -----------------------------------------------------------------------------
module ntsc_write
   import frame_pkg::*;
#(
   parameter int FRAME_WORDS = frame_pkg::FRAME_WORDS,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                frame_flag,
   input  logic [PIXEL_W-1:0]  pixel,
   input  logic                pixel_valid,
   output logic                ntsc_flag,
   output logic [WORD_W-1:0]   ntsc_pixel,
   output logic [ADDR_W-1:0]   ntsc_addr,
   input  logic                done_ntsc,
   output logic                overflow,
   output logic                frame_done
`ifdef NTSC_WRITE_STATS_EN
   ,
   output logic [15:0]         drop_count
`endif
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

   // ---------------------------------------------------------------- pack FSM
   pack_state_t         pack_state;
   pack_state_t         pack_next;
   logic [PIXEL_W-1:0]  half_q;
   logic [PIXEL_W-1:0]  half_d;
   logic [ADDR_W-1:0]   waddr_q;
   logic [ADDR_W-1:0]   waddr_d;
   logic                word_done;

   always_comb begin
      pack_next = pack_state;
      half_d    = half_q;
      waddr_d   = waddr_q;
      word_done = 1'b0;
      if (frame_flag) begin
         // New frame: any half pixel is discarded; a coincident pixel is
         // the first pixel of the new frame.
         waddr_d = '0;
         if (pixel_valid) begin
            half_d    = pixel;
            pack_next = PACK_HALF;
         end else begin
            pack_next = PACK_EMPTY;
         end
      end else if (pixel_valid) begin
         case (pack_state)
            PACK_EMPTY: begin
               half_d    = pixel;
               pack_next = PACK_HALF;
            end
            PACK_HALF: begin
               // Address advances even if the word is dropped, keeping later
               // pixels at their correct frame positions.
               word_done = 1'b1;
               waddr_d   = next_addr(waddr_q, LAST_ADDR);
               pack_next = PACK_EMPTY;
            end
            default: pack_next = PACK_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pack_state <= PACK_EMPTY;
         waddr_q    <= '0;
      end else begin
         pack_state <= pack_next;
         waddr_q    <= waddr_d;
      end
   end

   // Half-pixel holding register is pure data; pack_state qualifies it.
   always_ff @(posedge clock) begin
      half_q <= half_d;
   end

   // -------------------------------------------------------------- word FIFO
   logic [ENTRY_W-1:0]  fifo_head;
   logic [ENTRY_W-1:0]  fifo_head_next;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_more;
   logic                fifo_pop;

   word_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (ENTRY_W)
   ) u_word_fifo (
      .clock        (clock),
      .reset        (reset),
      .push         (word_done),
      .wr_data      ({waddr_q, half_q, pixel}),
      .pop          (fifo_pop),
      .rd_data      (fifo_head),
      .rd_data_next (fifo_head_next),
      .full         (fifo_full),
      .empty        (fifo_empty),
      .more         (fifo_more)
   );

   // --------------------------------------------------------------- write FSM
   wr_state_t  wr_state;
   wr_state_t  wr_next;
   logic       load_head;
   logic       load_next;

   always_comb begin
      wr_next   = wr_state;
      load_head = 1'b0;
      load_next = 1'b0;
      fifo_pop  = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (!fifo_empty) begin
               load_head = 1'b1;
               wr_next   = WR_REQ;
            end
         end
         WR_REQ: begin
            // The presented word stays in the FIFO until accepted, so the
            // entry behind it is what goes out back-to-back.
            if (done_ntsc) begin
               fifo_pop = 1'b1;
               if (fifo_more)
                  load_next = 1'b1;
               else
                  wr_next = WR_IDLE;
            end
         end
         default: wr_next = WR_IDLE;
      endcase
   end

   assign ntsc_flag = (wr_state == WR_REQ);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_state   <= WR_IDLE;
         ntsc_pixel <= '0;
         ntsc_addr  <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         wr_state <= wr_next;
         if (load_head)
            {ntsc_addr, ntsc_pixel} <= fifo_head;
         else if (load_next)
            {ntsc_addr, ntsc_pixel} <= fifo_head_next;
         // A pop in the same cycle frees the slot, so that push is not a drop.
         overflow   <= word_done && fifo_full && !fifo_pop;
         frame_done <= fifo_pop && (ntsc_addr == LAST_ADDR);
      end
   end

`ifdef NTSC_WRITE_STATS_EN
   // ------------------------------------------------------------- statistics
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF)
         return v;
      return v + 16'd1;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         drop_count <= '0;
      else if (word_done && fifo_full && !fifo_pop)
         drop_count <= sat_inc16(drop_count);
   end
`endif

endmodule

// File: tb/tb_ntsc_write.sv
// -----------------------------------------------------------------------------
// tb_ntsc_write
// Self-checking bench for ntsc_write. u_dut uses the default frame size;
// u_wrap shares the same inputs with FRAME_WORDS = 4 for the wrap case.
// -----------------------------------------------------------------------------
module tb_ntsc_write;

   logic        clock = 1'b0;
   logic        reset;
   logic        frame_flag;
   logic [17:0] pixel;
   logic        pixel_valid;
   logic        done_ntsc;

   logic        ntsc_flag;
   logic [35:0] ntsc_pixel;
   logic [17:0] ntsc_addr;
   logic        overflow;
   logic        frame_done;

   logic        w_flag;
   logic [35:0] w_pixel;
   logic [17:0] w_addr;
   logic        w_overflow;
   logic        w_frame_done;

`ifdef NTSC_WRITE_STATS_EN
   logic [15:0] drop_count;
   logic [15:0] w_drop_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ntsc_write u_dut (
      .clock       (clock),
      .reset       (reset),
      .frame_flag  (frame_flag),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .ntsc_flag   (ntsc_flag),
      .ntsc_pixel  (ntsc_pixel),
      .ntsc_addr   (ntsc_addr),
      .done_ntsc   (done_ntsc),
      .overflow    (overflow),
      .frame_done  (frame_done)
`ifdef NTSC_WRITE_STATS_EN
      ,
      .drop_count  (drop_count)
`endif
   );

   ntsc_write #(.FRAME_WORDS(4)) u_wrap (
      .clock       (clock),
      .reset       (reset),
      .frame_flag  (frame_flag),
      .pixel       (pixel),
      .pixel_valid (pixel_valid),
      .ntsc_flag   (w_flag),
      .ntsc_pixel  (w_pixel),
      .ntsc_addr   (w_addr),
      .done_ntsc   (done_ntsc),
      .overflow    (w_overflow),
      .frame_done  (w_frame_done)
`ifdef NTSC_WRITE_STATS_EN
      ,
      .drop_count  (w_drop_count)
`endif
   );

   typedef struct {
      logic        ff;
      logic        pv;
      logic [17:0] px;
      logic        done;
      logic        e_flag;
      logic [35:0] e_pix;
      logic [17:0] e_addr;
      logic        e_ovf;
      logic        e_fd;
   } vec_t;

   vec_t vt [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      frame_flag  = 1'b0;
      pixel_valid = 1'b0;
      pixel       = '0;
      done_ntsc   = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic wait_flag(input string name, input int max);
      for (int i = 0; i < max && !ntsc_flag; i++)
         step();
      check({name, "_flag_wait"}, 64'(ntsc_flag), 64'd1);
   endtask

   task automatic send_pair(input logic [17:0] a, input logic [17:0] b);
      pixel_valid = 1'b1;
      pixel = a;
      step();
      pixel = b;
      step();
      pixel_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [35:0] w0;
      logic [35:0] wf;
      logic [17:0] a;
      logic [17:0] b;
      int          ovf_cnt;
      int          n;
      int          fd_cnt;
      logic        prev_flag;
      logic [17:0] prev_addr;
      logic [17:0] exp_wrap [5];

      w0 = {18'h00001, 18'h00002};
      wf = {18'h3FFFF, 18'h00005};
      //          ff    pv    px         done  flag  pix  addr  ovf   fd
      vt[0]  = '{1'b0, 1'b1, 18'h00001, 1'b0, 1'b0, '0,  '0,   1'b0, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 18'h00002, 1'b0, 1'b0, '0,  '0,   1'b0, 1'b0};
      vt[2]  = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, w0,  '0,   1'b0, 1'b0};
      vt[3]  = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, w0,  '0,   1'b0, 1'b0};
      vt[4]  = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, w0,  '0,   1'b0, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 18'h00007, 1'b0, 1'b0, w0,  '0,   1'b0, 1'b0};
      vt[6]  = '{1'b1, 1'b1, 18'h3FFFF, 1'b0, 1'b0, w0,  '0,   1'b0, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 18'h00005, 1'b0, 1'b0, w0,  '0,   1'b0, 1'b0};
      vt[8]  = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b1, wf,  '0,   1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, wf,  '0,   1'b0, 1'b0};
      vt[10] = '{1'b0, 1'b0, 18'h00000, 1'b1, 1'b0, wf,  '0,   1'b0, 1'b0};

      // Reset state, checked before the first clock edge.
      reset       = 1'b1;
      frame_flag  = 1'b0;
      pixel_valid = 1'b0;
      pixel       = '0;
      done_ntsc   = 1'b0;
      #1;
      check("rst_flag", 64'(ntsc_flag), 64'd0);
      check("rst_pixel", 64'(ntsc_pixel), 64'd0);
      check("rst_addr", 64'(ntsc_addr), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      step();
      reset = 1'b0;

      // Basic pair, handshake hold, frame sync, ignored done.
      for (int i = 0; i < 11; i++) begin
         frame_flag  = vt[i].ff;
         pixel_valid = vt[i].pv;
         pixel       = vt[i].px;
         done_ntsc   = vt[i].done;
         step();
         check($sformatf("vec%0d_flag", i), 64'(ntsc_flag), 64'(vt[i].e_flag));
         check($sformatf("vec%0d_pixel", i), 64'(ntsc_pixel), 64'(vt[i].e_pix));
         check($sformatf("vec%0d_addr", i), 64'(ntsc_addr), 64'(vt[i].e_addr));
         check($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vt[i].e_ovf));
         check($sformatf("vec%0d_frame_done", i), 64'(frame_done), 64'(vt[i].e_fd));
      end
      frame_flag = 1'b0;
      done_ntsc  = 1'b0;

      // Stall / overflow: 12 pixels with no accepts.
      do_reset();
      ovf_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         pixel_valid = 1'b1;
         pixel = 18'(i + 1);
         step();
         if (overflow) ovf_cnt++;
      end
      pixel_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (overflow) ovf_cnt++;
      end
      check("stall_overflow_pulses", 64'(ovf_cnt), 64'd2);
      check("stall_flag", 64'(ntsc_flag), 64'd1);
      check("stall_addr", 64'(ntsc_addr), 64'd0);
`ifdef NTSC_WRITE_STATS_EN
      check("stall_drop_count", 64'(drop_count), 64'd2);
`endif
      done_ntsc = 1'b1;
      n = 0;
      for (int c = 0; c < 8; c++) begin
         if (ntsc_flag) begin
            a = 18'(2 * n + 1);
            b = 18'(2 * n + 2);
            check($sformatf("release%0d_addr", n), 64'(ntsc_addr), 64'(n));
            check($sformatf("release%0d_pixel", n), 64'(ntsc_pixel), 64'({a, b}));
            n++;
         end
         step();
      end
      done_ntsc = 1'b0;
      check("release_words", 64'(n), 64'd4);
      send_pair(18'h00020, 18'h00021);
      wait_flag("after_drop", 6);
      check("after_drop_addr", 64'(ntsc_addr), 64'd6);
      check("after_drop_pixel", 64'(ntsc_pixel), 64'({18'h00020, 18'h00021}));
      done_ntsc = 1'b1;
      step();
      done_ntsc = 1'b0;
      check("after_drop_flag_low", 64'(ntsc_flag), 64'd0);

      // Back-to-back: four queued words drained on consecutive cycles.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         pixel_valid = 1'b1;
         pixel = 18'(i + 1);
         step();
      end
      pixel_valid = 1'b0;
      step();
      step();
      done_ntsc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a = 18'(2 * k + 1);
         b = 18'(2 * k + 2);
         check($sformatf("b2b%0d_flag", k), 64'(ntsc_flag), 64'd1);
         check($sformatf("b2b%0d_addr", k), 64'(ntsc_addr), 64'(k));
         check($sformatf("b2b%0d_pixel", k), 64'(ntsc_pixel), 64'({a, b}));
         step();
      end
      check("b2b_flag_low", 64'(ntsc_flag), 64'd0);
      done_ntsc = 1'b0;

      // Wrap on the FRAME_WORDS = 4 instance, done held high.
      do_reset();
      exp_wrap[0] = 18'd0;
      exp_wrap[1] = 18'd1;
      exp_wrap[2] = 18'd2;
      exp_wrap[3] = 18'd3;
      exp_wrap[4] = 18'd0;
      done_ntsc = 1'b1;
      n = 0;
      fd_cnt = 0;
      prev_flag = 1'b0;
      prev_addr = '0;
      for (int c = 0; c < 24; c++) begin
         pixel_valid = (c < 10);
         pixel = 18'(c + 1);
         step();
         if (w_frame_done) begin
            fd_cnt++;
            check("wrap_fd_after_last", 64'({prev_flag, prev_addr}), 64'({1'b1, 18'd3}));
         end
         if (w_flag) begin
            if (n < 5)
               check($sformatf("wrap%0d_addr", n), 64'(w_addr), 64'(exp_wrap[n]));
            n++;
         end
         prev_flag = w_flag;
         prev_addr = w_addr;
      end
      done_ntsc = 1'b0;
      check("wrap_words", 64'(n), 64'd5);
      check("wrap_frame_done_pulses", 64'(fd_cnt), 64'd1);

      // Reset while a request is outstanding.
      do_reset();
      send_pair(18'h00003, 18'h00004);
      wait_flag("mid_rst", 6);
      reset = 1'b1;
      #1;
      check("mid_rst_flag", 64'(ntsc_flag), 64'd0);
      check("mid_rst_pixel", 64'(ntsc_pixel), 64'd0);
      check("mid_rst_addr", 64'(ntsc_addr), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      check("mid_rst_frame_done", 64'(frame_done), 64'd0);
      step();
      reset = 1'b0;
      send_pair(18'h00011, 18'h00022);
      wait_flag("post_rst", 6);
      check("post_rst_addr", 64'(ntsc_addr), 64'd0);
      check("post_rst_pixel", 64'(ntsc_pixel), 64'({18'h00011, 18'h00022}));
      done_ntsc = 1'b1;
      step();
      done_ntsc = 1'b0;
      check("post_rst_flag_low", 64'(ntsc_flag), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
